// File: rtl/serpent_lt_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : serpent_lt_fwd_pipe
// Brief    : Serpent forward linear transform, 1- or 2-stage valid/ready pipe.
// Revision : 1.0
// ============================================================================
module serpent_lt_fwd_pipe #(
  parameter bit TWO_STAGE = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    rotl = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lt_a(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    x0 = rotl(d[127:96], 13);
    x2 = rotl(d[63:32], 3);
    x1 = d[95:64] ^ x0 ^ x2;
    x3 = d[31:0] ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    lt_a = {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] lt_b(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    x1 = d[95:64];
    x3 = d[31:0];
    x0 = d[127:96] ^ x1 ^ x3;
    x2 = d[63:32] ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    lt_b = {x0, x1, x2, x3};
  endfunction

  logic         first_ld;
  logic         last_v;
  logic [127:0] last_d;
  logic         any_v;

  generate
    if (TWO_STAGE) begin : g_two
      logic         v1_q, v1_d, v2_q, v2_d;
      logic [127:0] d1_q, d1_d, d2_q, d2_d;
      logic         ld1, ld2;

      // Stage 2 frees up when drained; stage 1 whenever stage 2 advances.
      always_comb begin
        ld2  = !v2_q || i_ready;
        ld1  = !v1_q || ld2;
        v1_d = v1_q;
        d1_d = d1_q;
        v2_d = v2_q;
        d2_d = d2_q;
        if (ld1) begin
          v1_d = i_valid;
          if (i_valid) d1_d = lt_a(i_data);
        end
        if (ld2) begin
          v2_d = v1_q;
          if (v1_q) d2_d = lt_b(d1_q);
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          v1_q <= 1'b0;
          v2_q <= 1'b0;
        end else begin
          v1_q <= v1_d;
          v2_q <= v2_d;
        end
        d1_q <= d1_d;
        d2_q <= d2_d;
      end

      assign first_ld = ld1;
      assign last_v   = v2_q;
      assign last_d   = d2_q;
      assign any_v    = v1_q | v2_q;
    end else begin : g_one
      logic         v_q, v_d;
      logic [127:0] d_q, d_d;
      logic         ld;

      always_comb begin
        ld  = !v_q || i_ready;
        v_d = v_q;
        d_d = d_q;
        if (ld) begin
          v_d = i_valid;
          if (i_valid) d_d = lt_b(lt_a(i_data));
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          v_q <= 1'b0;
        end else begin
          v_q <= v_d;
        end
        d_q <= d_d;
      end

      assign first_ld = ld;
      assign last_v   = v_q;
      assign last_d   = d_q;
      assign any_v    = v_q;
    end
  endgenerate

  // Outputs are masked during reset so no partial transfer can be observed.
  assign o_ready = !i_rst && first_ld;
  assign o_valid = !i_rst && last_v;
  assign o_data  = o_valid ? last_d : 128'd0;
  assign o_busy  = !i_rst && any_v;

endmodule
`default_nettype wire

// File: tb/tb_serpent_lt_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_serpent_lt_fwd_pipe
// Brief    : Scoreboard bench for both pipeline depths of serpent_lt_fwd_pipe.
// Revision : 1.0
// ============================================================================
module tb_serpent_lt_fwd_pipe;

  int checks = 0;
  int errors = 0;
  bit done [2];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    rl = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    rr = rl(x, 32 - n);
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    x0 = rl(x0, 13);  x2 = rl(x2, 3);
    x1 = x1 ^ x0 ^ x2;  x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rl(x1, 1);   x3 = rl(x3, 7);
    x0 = x0 ^ x1 ^ x3;  x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rl(x0, 5);   x2 = rl(x2, 22);
    ref_fwd = {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    x2 = rr(x2, 22);  x0 = rr(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);  x0 = x0 ^ x1 ^ x3;
    x3 = rr(x3, 7);   x1 = rr(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);  x1 = x1 ^ x0 ^ x2;
    x2 = rr(x2, 3);   x0 = rr(x0, 13);
    ref_inv = {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] rand128();
    rand128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit TS    = (g == 0);
    localparam int DEPTH = TS ? 2 : 1;

    logic         rst, vld_i, rdy_o, vld_o, rdy_i, busy_o;
    logic [127:0] data_i, data_o;
    logic [127:0] sb_q [$];
    logic [127:0] held;
    bit           held_v;
    int           cur_run, max_run;

    serpent_lt_fwd_pipe #(.TWO_STAGE(TS)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (vld_i),
      .o_ready (rdy_o),
      .i_data  (data_i),
      .o_valid (vld_o),
      .i_ready (rdy_i),
      .o_data  (data_o),
      .o_busy  (busy_o)
    );

    function automatic string nm(input string s);
      nm = $sformatf("ts%0d %s", TS, s);
    endfunction

    // Monitor: pops and checks every transferred output, pushes every accept.
    always @(negedge clk) begin
      logic [127:0] src;
      if (rst) begin
        sb_q.delete();
        held_v = 1'b0;
      end else begin
        if (!vld_o) check(nm("idle data gated"), data_o, 128'd0);
        if (held_v) begin
          check(nm("hold valid"), {127'd0, vld_o}, 128'd1);
          check(nm("hold data"), data_o, held);
        end
        held_v = vld_o && !rdy_i;
        held   = data_o;
        if (vld_o && rdy_i) begin
          cur_run++;
          if (cur_run > max_run) max_run = cur_run;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h, expected no output", nm("unexpected out"), data_o);
          end else begin
            src = sb_q.pop_front();
            check(nm("fwd data"), data_o, ref_fwd(src));
            check(nm("inverse roundtrip"), ref_inv(data_o), src);
          end
        end else begin
          cur_run = 0;
        end
        if (vld_i && rdy_o) sb_q.push_back(data_i);
      end
    end

    task automatic send(input logic [127:0] d);
      bit acc;
      acc    = 1'b0;
      vld_i  = 1'b1;
      data_i = d;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (rdy_o) begin
          acc = 1'b1;
          break;
        end
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL %s: got no accept, expected accept within 200 cycles", nm("send"));
      end
      @(posedge clk); #1;
      vld_i = 1'b0;
    endtask

    task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
        @(negedge clk);
        if (sb_q.size() == 0 && !busy_o) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: got %0d pending, expected 0", nm("drain"), sb_q.size());
      end
      @(posedge clk); #1;
    endtask

    initial begin
      int n, acc_cnt, low_cnt, sent, cyc;
      bit acc;
      rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; data_i = '0;
      cur_run = 0; max_run = 0;
      @(posedge clk); #1;
      @(negedge clk);
      check(nm("reset ready"), {127'd0, rdy_o}, 128'd0);
      check(nm("reset valid"), {127'd0, vld_o}, 128'd0);
      check(nm("reset busy"), {127'd0, busy_o}, 128'd0);
      check(nm("reset data"), data_o, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check(nm("ready after reset"), {127'd0, rdy_o}, 128'd1);
      @(posedge clk); #1;

      // Single known-answer block and its latency.
      rdy_i = 1'b1;
      send(128'h00000001_00000000_00000000_00000000);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!vld_o && n < 10);
      check(nm("latency"), 128'(n), 128'(DEPTH));
      check(nm("kat data"), data_o, 128'h100C0000_00004000_00002800_00800000);
      @(negedge clk);
      check(nm("single valid pulse"), {127'd0, vld_o}, 128'd0);
      @(posedge clk); #1;

      send(128'd0);
      drain();

      // Back-to-back stream with no downstream stall.
      max_run = 0;
      low_cnt = 0;
      vld_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
        data_i = rand128();
        @(negedge clk);
        if (!rdy_o) low_cnt++;
        @(posedge clk); #1;
      end
      vld_i = 1'b0;
      drain();
      check(nm("stream ready lows"), 128'(low_cnt), 128'd0);
      check(nm("stream run length"), 128'(max_run), 128'd16);

      // Backpressure fills the pipe, then releases.
      rdy_i   = 1'b0;
      acc_cnt = 0;
      vld_i   = 1'b1;
      data_i  = rand128();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        acc = rdy_o;
        @(posedge clk); #1;
        if (acc) begin
          acc_cnt++;
          data_i = rand128();
        end
      end
      @(negedge clk);
      check(nm("bp accepts"), 128'(acc_cnt), 128'(DEPTH));
      check(nm("bp ready low"), {127'd0, rdy_o}, 128'd0);
      @(posedge clk); #1;
      vld_i = 1'b0;
      rdy_i = 1'b1;
      drain();

      // Random valid/ready traffic.
      sent = 0;
      cyc  = 0;
      vld_i = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
        if (!vld_i && ($urandom % 4 != 0)) begin
          vld_i  = 1'b1;
          data_i = rand128();
        end
        rdy_i = ($urandom % 4 != 0);
        @(negedge clk);
        acc = vld_i && rdy_o;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          sent++;
          vld_i = 1'b0;
        end
      end
      vld_i = 1'b0;
      rdy_i = 1'b1;
      check(nm("random sent"), 128'(sent), 128'd10000);
      drain();

      // Reset with the pipe full; nothing may come out afterwards.
      rdy_i = 1'b0;
      repeat (DEPTH) send(rand128());
      @(negedge clk);
      check(nm("busy before reset"), {127'd0, busy_o}, 128'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check(nm("valid during reset"), {127'd0, vld_o}, 128'd0);
      check(nm("ready during reset"), {127'd0, rdy_o}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check(nm("valid after reset"), {127'd0, vld_o}, 128'd0);
      check(nm("busy after reset"), {127'd0, busy_o}, 128'd0);
      check(nm("ready after mid reset"), {127'd0, rdy_o}, 128'd1);
      @(posedge clk); #1;
      rdy_i = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check(nm("no stale output"), {127'd0, vld_o}, 128'd0);
      end
      @(posedge clk); #1;
      send(rand128());
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 90000; c++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL global timeout: got unfinished bench, expected completion");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
